// File: rtl/mem_access_pipe.sv
// Memory-access stage: single-cycle writeback of ALU/branch ops, and a REQ/WAIT handshake for loads and stores.
// Optional load-response watchdog and sticky mem_err are enabled by defining MEM_TIMEOUT_EN.
module mem_access_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4,
  parameter int MADDR_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [MADDR_W-1:0] mem_addr_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               wr_en_in,
  input  logic               ld_in,
  input  logic               st_in,
  input  logic               beq_in,
  input  logic               bne_in,
  input  logic [MADDR_W-1:0] br_target_in,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_we,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               out_valid,
  output logic [DATA_W-1:0]  result_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic               wr_en_out,
  output logic               branch_taken,
  output logic [MADDR_W-1:0] branch_target,
  output logic               branch_flush,
  output logic               busy
`ifdef MEM_TIMEOUT_EN
  ,
  output logic               mem_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state, state_nx;
  logic [RADDR_W-1:0] rd_q;
  logic               accept, acc_mem, acc_alu, is_br, br_hit;
  logic               st_hs, ld_hs, rsp_hit, tmo;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign busy          = (state != IDLE);

  assign accept  = in_valid && in_ready;
  assign acc_mem = accept && (ld_in || st_in);
  assign acc_alu = accept && !(ld_in || st_in);
  assign is_br   = beq_in || bne_in;
  // Compare result of 1 means the tested condition held, for either branch flavour.
  always_comb begin
    br_hit = 1'b0;
    if (beq_in)      br_hit = (alu_result_in == DATA_W'(1));
    else if (bne_in) br_hit = (alu_result_in == DATA_W'(1));
  end

  assign st_hs   = (state == REQ) && mem_req_ready && mem_we;
  assign ld_hs   = (state == REQ) && mem_req_ready && !mem_we;
  assign rsp_hit = (state == WAIT) && mem_rsp_valid;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign tmo = (state == WAIT) && !mem_rsp_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT && state_nx == WAIT) ? wait_cnt + 1'b1 : '0;
      if (tmo) mem_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc_mem) state_nx = REQ;
      REQ:     if (st_hs) state_nx = IDLE;
               else if (ld_hs) state_nx = WAIT;
      WAIT:    if (rsp_hit || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request payload is captured at acceptance so it stays stable while REQ stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_q      <= '0;
    end else if (acc_mem) begin
      mem_we    <= st_in;
      mem_addr  <= mem_addr_in;
      mem_wdata <= store_data_in;
      rd_q      <= rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      result_out    <= '0;
      rd_out        <= '0;
      wr_en_out     <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      branch_flush  <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
      branch_flush <= 1'b0;
      if (acc_alu) begin
        out_valid     <= 1'b1;
        result_out    <= alu_result_in;
        rd_out        <= rd_in;
        wr_en_out     <= wr_en_in && !is_br;
        branch_flush  <= is_br;
        branch_taken  <= is_br && br_hit;
        branch_target <= (is_br && br_hit) ? br_target_in : '0;
      end else if (st_hs) begin
        out_valid  <= 1'b1;
        result_out <= '0;
        rd_out     <= rd_q;
        wr_en_out  <= 1'b0;
      end else if (rsp_hit) begin
        out_valid  <= 1'b1;
        result_out <= mem_rdata;
        rd_out     <= rd_q;
        wr_en_out  <= 1'b1;
      end else if (tmo) begin
        out_valid  <= 1'b1;
        result_out <= '0;
        rd_out     <= rd_q;
        wr_en_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_pipe.sv
// Directed bench for mem_access_pipe; timeout checks are included when MEM_TIMEOUT_EN is defined.
module tb_mem_access_pipe;
  localparam int DATA_W = 32, RADDR_W = 4, MADDR_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready;
  logic [DATA_W-1:0]  alu_result_in, store_data_in;
  logic [MADDR_W-1:0] mem_addr_in, br_target_in;
  logic [RADDR_W-1:0] rd_in;
  logic               wr_en_in, ld_in, st_in, beq_in, bne_in;
  logic               mem_req_valid, mem_req_ready, mem_we;
  logic [MADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rdata;
  logic               out_valid, wr_en_out;
  logic [DATA_W-1:0]  result_out;
  logic [RADDR_W-1:0] rd_out;
  logic               branch_taken, branch_flush, busy;
  logic [MADDR_W-1:0] branch_target;
`ifdef MEM_TIMEOUT_EN
  logic               mem_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .MADDR_W(MADDR_W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .mem_addr_in(mem_addr_in),
    .rd_in(rd_in), .wr_en_in(wr_en_in), .ld_in(ld_in), .st_in(st_in), .beq_in(beq_in),
    .bne_in(bne_in), .br_target_in(br_target_in), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .result_out(result_out), .rd_out(rd_out), .wr_en_out(wr_en_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .branch_flush(branch_flush),
    .busy(busy)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_valid = 0; alu_result_in = 0; store_data_in = 0; mem_addr_in = 0; rd_in = 0;
    wr_en_in = 0; ld_in = 0; st_in = 0; beq_in = 0; bne_in = 0; br_target_in = 0;
  endtask

  initial begin
    idle_in();
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    reset = 0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result_out, 0);
    chk("rst_flush", branch_flush, 0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_mem_err", mem_err, 0);
`endif
    reset = 1;

    // ALU op
    in_valid = 1; alu_result_in = 32'h1234; rd_in = 5; wr_en_in = 1;
    step();
    chk("alu_out_valid", out_valid, 1);
    chk("alu_result", result_out, 32'h1234);
    chk("alu_rd", rd_out, 5);
    chk("alu_wr_en", wr_en_out, 1);
    idle_in();
    step();
    chk("alu_pulse_end", out_valid, 0);

    // Taken branch, then not-taken
    in_valid = 1; beq_in = 1; alu_result_in = 1; br_target_in = 9; wr_en_in = 1;
    step();
    chk("br_taken", branch_taken, 1);
    chk("br_target", branch_target, 9);
    chk("br_flush", branch_flush, 1);
    chk("br_wr_en", wr_en_out, 0);
    idle_in();
    step();
    chk("br_taken_end", branch_taken, 0);
    chk("br_flush_end", branch_flush, 0);
    in_valid = 1; beq_in = 1; alu_result_in = 0; br_target_in = 9;
    step();
    chk("brnt_flush", branch_flush, 1);
    chk("brnt_taken", branch_taken, 0);
    idle_in();

    // Store with 4 stalled cycles
    in_valid = 1; st_in = 1; mem_addr_in = 3; store_data_in = 32'hA5;
    step();
    idle_in(); mem_addr_in = 4'hF; store_data_in = 32'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("st_req_valid", mem_req_valid, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 3);
      chk("st_wdata", mem_wdata, 32'hA5);
      chk("st_in_ready", in_ready, 0);
      chk("st_busy", busy, 1);
      if (i < 3) step();
    end
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("st_out_valid", out_valid, 1);
    chk("st_wr_en", wr_en_out, 0);
    chk("st_req_drop", mem_req_valid, 0);
    chk("st_idle", in_ready, 1);
    step();
    chk("st_pulse_end", out_valid, 0);

    // Load with response 3 cycles after handshake
    in_valid = 1; ld_in = 1; mem_addr_in = 2; rd_in = 7;
    step();
    idle_in();
    chk("ld_req_valid", mem_req_valid, 1);
    chk("ld_we", mem_we, 0);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("ld_wait_req_drop", mem_req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      chk("ld_wait_in_ready", in_ready, 0);
      chk("ld_wait_out_valid", out_valid, 0);
      step();
    end
    chk("ld_wait_in_ready", in_ready, 0);
    mem_rsp_valid = 1; mem_rdata = 32'hDEAD;
    step();
    mem_rsp_valid = 0; mem_rdata = 0;
    chk("ld_out_valid", out_valid, 1);
    chk("ld_result", result_out, 32'hDEAD);
    chk("ld_wr_en", wr_en_out, 1);
    chk("ld_rd", rd_out, 7);
    chk("ld_idle", in_ready, 1);

    // Response outside WAIT is ignored
    mem_rsp_valid = 1; mem_rdata = 32'h55;
    step();
    mem_rsp_valid = 0;
    chk("rsp_idle_ignored", out_valid, 0);

    // Reset during WAIT
    in_valid = 1; ld_in = 1; rd_in = 3;
    step();
    idle_in();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("rw_in_wait", busy, 1);
    reset = 0;
    step();
    reset = 1;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_busy", busy, 0);
    mem_rsp_valid = 1; mem_rdata = 32'hBEEF;
    step();
    mem_rsp_valid = 0;
    chk("rw_late_rsp", out_valid, 0);

    // Reset during REQ
    in_valid = 1; ld_in = 1;
    step();
    idle_in();
    chk("rr_req", mem_req_valid, 1);
    reset = 0;
    step();
    reset = 1;
    chk("rr_req_drop", mem_req_valid, 0);
    chk("rr_out_valid", out_valid, 0);

    // ld and st together behave as store
    in_valid = 1; ld_in = 1; st_in = 1; mem_addr_in = 6; store_data_in = 32'h77;
    step();
    idle_in();
    chk("ldst_we", mem_we, 1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("ldst_out_valid", out_valid, 1);
    chk("ldst_wr_en", wr_en_out, 0);
    chk("ldst_idle", in_ready, 1);

`ifdef MEM_TIMEOUT_EN
    in_valid = 1; ld_in = 1; rd_in = 2;
    step();
    idle_in();
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("tmo_wait_out_valid", out_valid, 0);
    end
    step();
    chk("tmo_out_valid", out_valid, 1);
    chk("tmo_result", result_out, 0);
    chk("tmo_wr_en", wr_en_out, 0);
    chk("tmo_mem_err", mem_err, 1);
    chk("tmo_idle", in_ready, 1);
    step(); step();
    chk("tmo_mem_err_sticky", mem_err, 1);
    reset = 0;
    step();
    reset = 1;
    chk("tmo_mem_err_clr", mem_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
